// File: rtl/dma_copy_engine.sv
// Block-copy sequencer for the DMA port of the dual-port memory controller.
// Each word is one read request, then one write request, each waiting for DMAValid.
module dma_copy_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [ADDR_WIDTH-1:0] SrcAddr,
    input  logic [ADDR_WIDTH-1:0] DstAddr,
    input  logic [ADDR_WIDTH-1:0] Len,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] Count,
    output logic                  DMAEn,
    output logic                  DMAWrEn,
    output logic [ADDR_WIDTH-1:0] DMAAddr,
    output logic [DATA_WIDTH-1:0] DMAData,
    input  logic [DATA_WIDTH-1:0] DMAOut,
    input  logic                  DMAValid
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFin
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic                  abort_q;
    logic                  abort_seen;

    // An Abort arriving in the same cycle as the completion still counts.
    assign abort_seen = abort_q | (Busy & Abort);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            abort_q <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Count   <= '0;
            DMAEn   <= 1'b0;
            DMAWrEn <= 1'b0;
            DMAAddr <= '0;
            DMAData <= '0;
        end else begin
            DMAEn   <= 1'b0;
            DMAWrEn <= 1'b0;
            Done    <= 1'b0;
            if (Busy && Abort) begin
                abort_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    abort_q <= 1'b0;
                    if (Start) begin
                        Count <= '0;
                        if (Len != '0) begin
                            src_q   <= SrcAddr;
                            dst_q   <= DstAddr;
                            rem_q   <= Len;
                            Busy    <= 1'b1;
                            DMAEn   <= 1'b1;
                            DMAAddr <= SrcAddr;
                            state_q <= StRdReq;
                        end else begin
                            Done    <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                end
                StRdReq: begin
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    if (DMAValid) begin
                        if (abort_seen) begin
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            DMAData <= DMAOut;
                            DMAEn   <= 1'b1;
                            DMAWrEn <= 1'b1;
                            DMAAddr <= dst_q;
                            state_q <= StWrReq;
                        end
                    end
                end
                StWrReq: begin
                    state_q <= StWrWait;
                end
                StWrWait: begin
                    if (DMAValid) begin
                        Count <= Count + 1'b1;
                        src_q <= src_q + 1'b1;
                        dst_q <= dst_q + 1'b1;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == ADDR_WIDTH'(1) || abort_seen) begin
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            DMAEn   <= 1'b1;
                            DMAAddr <= src_q + 1'b1;
                            state_q <= StRdReq;
                        end
                    end
                end
                StFin: begin
                    abort_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a behavioural memory controller
// that answers each request after a programmable delay.
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [15:0] SrcAddr = '0;
    logic [15:0] DstAddr = '0;
    logic [15:0] Len = '0;
    logic        Busy, Done, DMAEn, DMAWrEn;
    logic [15:0] Count, DMAAddr;
    logic [31:0] DMAData;
    logic [31:0] DMAOut = '0;
    logic        DMAValid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    dma_copy_engine #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Abort   (Abort),
        .SrcAddr (SrcAddr),
        .DstAddr (DstAddr),
        .Len     (Len),
        .Busy    (Busy),
        .Done    (Done),
        .Count   (Count),
        .DMAEn   (DMAEn),
        .DMAWrEn (DMAWrEn),
        .DMAAddr (DMAAddr),
        .DMAData (DMAData),
        .DMAOut  (DMAOut),
        .DMAValid(DMAValid)
    );

    always #5 clk = ~clk;

    // Memory model state, written only by the responder process below.
    logic [31:0] mem [0:65535];
    logic [15:0] log_addr [$];
    bit          log_wr [$];
    int          en_pulses = 0;
    int          en_twice = 0;
    int          wr_bad = 0;
    int          done_pulses = 0;
    int          pend = 0;
    bit          prev_en = 1'b0;
    bit          p_wr = 1'b0;
    logic [15:0] p_addr = '0;
    logic [31:0] p_data = '0;
    // Controlled by the main process only.
    bit          use_table = 1'b0;
    int          fixed_delay = 1;

    always @(negedge clk) begin
        DMAValid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                DMAValid = 1'b1;
                if (p_wr) mem[p_addr] = p_data;
                else DMAOut = mem[p_addr];
            end
        end
        if (DMAEn) begin
            en_pulses++;
            if (prev_en) en_twice++;
            log_addr.push_back(DMAAddr);
            log_wr.push_back(DMAWrEn);
            p_wr   = DMAWrEn;
            p_addr = DMAAddr;
            p_data = DMAData;
            pend   = use_table ? ((en_pulses * 5 + 2) % 6) + 1 : fixed_delay;
        end
        if (!DMAEn && DMAWrEn) wr_bad++;
        if (Done) done_pulses++;
        prev_en = DMAEn;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        Start   = 1'b1;
        SrcAddr = src;
        DstAddr = dst;
        Len     = len;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Returns in the cycle Done is seen; cyc counts that cycle and the current one.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (Done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (Done !== 1'b1) check_eq("done_timeout", 0, 1);
    endtask

    task automatic wait_req(input bit wr, input logic [15:0] addr, input int budget);
        int n = 0;
        while (!(DMAEn && DMAWrEn == wr && DMAAddr == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(DMAEn && DMAWrEn == wr && DMAAddr == addr)) check_eq("req_timeout", addr, 16'hdead);
    endtask

    int          cyc;
    int          base_en;
    int          base_log;
    int          base_done;
    bit          alt_ok;
    logic [15:0] exp_addr [6];
    logic [31:0] exp_w [4];

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Done, 0);
        check_eq("rst_count", Count, 0);
        check_eq("rst_en", {DMAEn, DMAWrEn}, 0);
        check_eq("rst_addr_data", {DMAAddr, DMAData}, 0);
        @(negedge clk);

        // Uncontended copy of four words.
        exp_w = '{32'd11, 32'd22, 32'd33, 32'd44};
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = exp_w[i];
        base_en = en_pulses;
        do_start(16'h0010, 16'h0100, 16'd4);
        check_eq("t1_first_req", {Busy, DMAEn, DMAWrEn, DMAAddr}, {3'b110, 16'h0010});
        wait_done(60, cyc);
        check_eq("t1_cycles", cyc, 17);
        check_eq("t1_busy_at_done", Busy, 0);
        check_eq("t1_count", Count, 4);
        check_eq("t1_pulses", en_pulses - base_en, 8);
        for (int i = 0; i < 4; i++) check_eq("t1_data", mem[16'h0100 + i], exp_w[i]);
        @(negedge clk);
        check_eq("t1_done_one_cycle", Done, 0);

        // Stalled controller, eight words.
        use_table = 1'b1;
        for (int i = 0; i < 8; i++) mem[16'h0200 + i] = 32'hA000_0000 + 32'(i * 7);
        base_en  = en_pulses;
        base_log = log_addr.size();
        do_start(16'h0200, 16'h0300, 16'd8);
        wait_done(400, cyc);
        check_eq("t2_count", Count, 8);
        check_eq("t2_pulses", en_pulses - base_en, 16);
        check_eq("t2_single_cycle", en_twice, 0);
        check_eq("t2_wren_qualified", wr_bad, 0);
        alt_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (log_wr[base_log + i] != bit'(i % 2)) alt_ok = 1'b0;
        check_eq("t2_alternate", alt_ok, 1);
        for (int i = 0; i < 8; i++)
            check_eq("t2_data", mem[16'h0300 + i], 32'hA000_0000 + 32'(i * 7));
        use_table = 1'b0;
        @(negedge clk);

        // Address wrap-around.
        mem[16'hFFFE] = 32'h1111_0001;
        mem[16'hFFFF] = 32'h1111_0002;
        mem[16'h0000] = 32'h1111_0003;
        base_log = log_addr.size();
        do_start(16'hFFFE, 16'h7FFF, 16'd3);
        wait_done(60, cyc);
        exp_addr = '{16'hFFFE, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h8001};
        for (int i = 0; i < 6; i++) check_eq("t3_addr", log_addr[base_log + i], exp_addr[i]);
        check_eq("t3_data0", mem[16'h7FFF], 32'h1111_0001);
        check_eq("t3_data2", mem[16'h8001], 32'h1111_0003);
        @(negedge clk);

        // Abort during the second word's read wait.
        fixed_delay = 3;
        mem[16'h1000] = 32'h0BAD_0001;
        mem[16'h1001] = 32'h0BAD_0002;
        mem[16'h2001] = 32'h5555_5555;
        base_en   = en_pulses;
        base_done = done_pulses;
        do_start(16'h1000, 16'h2000, 16'd10);
        wait_req(1'b0, 16'h1001, 40);
        @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        wait_done(60, cyc);
        check_eq("t4_count", Count, 1);
        check_eq("t4_busy", Busy, 0);
        check_eq("t4_pulses", en_pulses - base_en, 3);
        check_eq("t4_first_word", mem[16'h2000], 32'h0BAD_0001);
        check_eq("t4_no_second_write", mem[16'h2001], 32'h5555_5555);
        fixed_delay = 1;
        @(negedge clk);
        check_eq("t4_done_pulses", done_pulses - base_done, 1);

        // Len = 0 finishes at once with no requests.
        base_en = en_pulses;
        do_start(16'h0040, 16'h0050, 16'd0);
        check_eq("t5_len0_done", {Done, Busy}, 2'b10);
        check_eq("t5_len0_count", Count, 0);
        @(negedge clk);
        check_eq("t5_len0_pulses", en_pulses - base_en, 0);
        check_eq("t5_len0_done_drop", Done, 0);

        // Start while busy is ignored.
        mem[16'h0400] = 32'hCAFE_0000;
        mem[16'h0401] = 32'hCAFE_0001;
        base_en  = en_pulses;
        base_log = log_addr.size();
        do_start(16'h0400, 16'h0500, 16'd2);
        @(negedge clk);
        do_start(16'h0600, 16'h0700, 16'd5);
        wait_done(60, cyc);
        check_eq("t5_busy_start_pulses", en_pulses - base_en, 4);
        check_eq("t5_busy_start_count", Count, 2);
        check_eq("t5_busy_start_wr1", log_addr[base_log + 3], 16'h0501);
        check_eq("t5_busy_start_data", mem[16'h0501], 32'hCAFE_0001);
        @(negedge clk);

        // Synchronous reset during the second word's write wait.
        fixed_delay = 5;
        mem[16'h0A00] = 32'h7777_0000;
        mem[16'h0A01] = 32'h7777_0001;
        base_done = done_pulses;
        do_start(16'h0A00, 16'h0800, 16'd2);
        wait_req(1'b1, 16'h0801, 60);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_ctrl", {Busy, Done, DMAEn, DMAWrEn}, 0);
        check_eq("t6_rst_count", Count, 0);
        check_eq("t6_rst_addr", DMAAddr, 0);
        check_eq("t6_rst_data", DMAData, 0);
        base_en = en_pulses;
        repeat (8) @(negedge clk);
        check_eq("t6_late_valid_busy", Busy, 0);
        check_eq("t6_late_valid_pulses", en_pulses - base_en, 0);
        check_eq("t6_no_done", done_pulses - base_done, 0);
        check_eq("t6_late_valid_count", Count, 0);
        fixed_delay = 1;
        do_start(16'h0A01, 16'h0900, 16'd1);
        wait_done(30, cyc);
        check_eq("t6_after_rst_cycles", cyc, 5);
        check_eq("t6_after_rst_count", Count, 1);
        check_eq("t6_after_rst_data", mem[16'h0900], 32'h7777_0001);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Sequencer that drives the DMA port of the shared dual-port memory controller to copy a block of words from a source region to a destination region. It is configured and started by the CPU, with one start pulse per transfer. Each word is issued as a single-cycle read request followed by a single-cycle write request. The engine waits for DMAValid between requests, so it tolerates the controller's lowest-priority stalls and buffering.

## Interface
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 16, word address width; also the width of Len and Count.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- Start  in  1  one-cycle start pulse; sampled only in IDLE.
- Abort  in  1  stop after the access currently in flight completes.
- SrcAddr, DstAddr  in  ADDR_WIDTH  first source and destination word addresses; latched at Start.
- Len  in  ADDR_WIDTH  number of words to copy; latched at Start.
- Busy  out  1  high from the cycle after an accepted Start until the end of the transfer.
- Done  out  1  one-cycle pulse when the transfer ends (complete, aborted, or Len=0).
- Count  out  ADDR_WIDTH  number of words fully written in the current or last transfer.
- DMAEn  out  1  request pulse to the memory controller.
- DMAWrEn  out  1  write qualifier for DMAEn.
- DMAAddr  out  ADDR_WIDTH  request address.
- DMAData  out  DATA_WIDTH  write data.
- DMAOut  in  DATA_WIDTH  read data; valid in the cycle DMAValid is high.
- DMAValid  in  1  access completion from the controller.

## Operation
- Reset values: all outputs 0; FSM in IDLE; internal address, length and data registers 0.
- FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - Start=1 with Len≠0: latch SrcAddr, DstAddr and Len, clear Count, go to RD_REQ.
  - Start=1 with Len=0: clear Count, go to FIN.
- RD_REQ: DMAEn=1, DMAWrEn=0, DMAAddr=src pointer; go to RD_WAIT.
- RD_WAIT: hold DMAEn=0.
  - On DMAValid=1: capture DMAOut into the data register and go to WR_REQ.
  - If Abort has been seen, go to FIN instead.
- WR_REQ: DMAEn=1, DMAWrEn=1, DMAAddr=dst pointer, DMAData=data register; go to WR_WAIT.
- WR_WAIT: on DMAValid=1:
  - Count+1, src+1, dst+1, remaining-1.
  - If remaining becomes 0, or Abort has been seen, go to FIN; otherwise go to RD_REQ.
- FIN: Done=1 for this cycle only, Busy=0; go to IDLE.
- Abort handling:
  - Abort is sticky: it is set on any cycle with Busy=1 and cleared on entry to IDLE.
  - It never cancels a request already issued; the engine always waits for that request's DMAValid.
  - Abort in IDLE has no effect.
- Start while Busy=1 is ignored; the latched configuration is unchanged.
- Pointers wrap modulo 2^ADDR_WIDTH; FFFF+1 becomes 0000 at the default width.
- Overlapping source and destination regions are copied in ascending address order with no hazard protection.
- DMAValid seen in IDLE, RD_REQ, WR_REQ or FIN is ignored.
- DMAAddr and DMAData hold their last value when DMAEn=0. DMAWrEn is 0 whenever DMAEn=0.

## Timing
- If Start is sampled at edge N, RD_REQ is active in cycle N+1 and Busy=1 from cycle N+1.
- DMAEn is high for exactly one cycle per access. The memory controller's internal buffer holds a blocked request, so the engine never re-issues one.
- Uncontended, DMAValid arrives the cycle after DMAEn, giving 4 cycles per word. A transfer of L words takes 4L+1 cycles from the first RD_REQ to Done, inclusive.
- Contention stretches RD_WAIT and WR_WAIT by the stall length, with no upper bound and no timeout.
- Done is asserted in the same cycle Busy falls. A new Start is accepted in the cycle after Done.
- Len=0: Done is asserted at N+1, with Busy staying 0 and no DMAEn.
- Synchronous reset mid-transfer:
  - Next cycle is IDLE, all outputs are 0, and no Done pulse is generated.
  - A DMAValid arriving after reset is ignored.

## Test plan
- Uncontended copy (DMAValid=1 the cycle after each DMAEn):
  - Stimulus: memory [0x0010..0x0013] = 11,22,33,44; Src=0x0010, Dst=0x0100, Len=4.
  - Response: [0x0100..0x0103] = 11,22,33,44; Done 17 cycles after the first DMAEn; Count=4.
- Stalled controller:
  - Stimulus: DMAValid delayed by a random 1-6 cycles per access; Len=8.
  - Response: exactly 16 single-cycle DMAEn pulses, with reads and writes alternating; data correct; Count=8.
- Wrap-around:
  - Stimulus: Src=0xFFFE, Dst=0x7FFF, Len=3.
  - Response: reads 0xFFFE, 0xFFFF, 0x0000; writes 0x7FFF, 0x8000, 0x8001.
- Abort:
  - Stimulus: Abort pulsed during the second word's RD_WAIT of a Len=10 transfer.
  - Response: the read completes with no write for it; Done is asserted; Count=1; Busy=0.
- Len=0, and Start while busy:
  - Len=0 gives Done at N+1 with no DMAEn and Count=0.
  - A second Start during a Len=2 transfer is ignored, with exactly 4 DMAEn pulses in total.
- Reset mid-transfer:
  - Stimulus: rst=1 for one cycle during WR_WAIT.
  - Response: all outputs 0 the next cycle, no Done pulse, and a late DMAValid is ignored.
  - A following Start with Len=1 completes normally.
